subword_mem_access: RTL and testbench

- Data-memory access stage of the MEM pipeline step, between the EX/MEM register and a single-port synchronous data RAM that has no byte enables.
- Performs word stores directly. Performs byte/halfword stores as read-modify-write.
- For loads, returns the addressed lane right-justified so the downstream load mask can zero the upper bits.
- Stalls the pipeline via a ready/valid handshake while an access is in flight.

---
 rtl/subword_mem_access.sv | 79 +++++++
 tb/tb_subword_mem_access.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/subword_mem_access.sv
// subword_mem_access: MEM-stage data access with read-modify-write sub-word stores over a byte-enable-less RAM.
// Optional misalignment check enabled by defining SUBWORD_ALIGN_CHECK_EN.
module subword_mem_access #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, MERGE, RESP} state_t;
  state_t state, nextState;
  logic capWrite, capErr, misAlign, isWord, accept, unusedAddr;
  logic [1:0] capSize, capOff;
  logic [ADDR_W-1:0] capWord;
  logic [31:0] capWdata, rdataReg, loadData, laneMask, mergeData;
  logic [4:0] laneShift;
  assign unusedAddr = ^req_addr[31:ADDR_W+2];
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign isWord = req_size == 2'd0 || req_size == 2'd3;
`ifdef SUBWORD_ALIGN_CHECK_EN
  assign misAlign = (req_size == 2'd1 && req_addr[0]) || (isWord && req_addr[1:0] != 2'd0);
`else
  assign misAlign = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      capWrite <= 1'b0;
      capErr <= 1'b0;
      capSize <= 2'd0;
      capOff <= 2'd0;
      capWord <= '0;
      capWdata <= '0;
      rdataReg <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        capWrite <= req_write;
        capErr <= misAlign;
        capSize <= req_size;
        capOff <= req_addr[1:0];
        capWord <= req_addr[ADDR_W+1:2];
        capWdata <= req_wdata;
      end
      if (state == RESP && !capErr) rdataReg <= loadData;
    end
  end
  always_comb begin
    nextState = IDLE;
    if (state == IDLE)
      nextState = !req_valid ? IDLE : misAlign ? RESP : (req_write && isWord) ? WRITE : READ;
    else if (state == READ)
      nextState = capWrite ? MERGE : RESP;
  end
  // One shift amount serves both the load extraction and the store lane insertion.
  assign laneShift = capSize == 2'd2 ? {capOff, 3'b000} : capSize == 2'd1 ? {capOff[1], 4'b0000} : 5'd0;
  assign loadData = mem_rdata >> laneShift;
  assign laneMask = (capSize == 2'd2 ? 32'h0000_00ff : 32'h0000_ffff) << laneShift;
  assign mergeData = (mem_rdata & ~laneMask) | ((capWdata << laneShift) & laneMask);
  assign mem_addr = capWord;
  assign mem_we = state == WRITE || state == MERGE;
  assign mem_wdata = state == MERGE ? mergeData : capWdata;
  assign resp_valid = state == WRITE || state == MERGE || state == RESP;
  assign resp_rdata = (state == RESP && !capErr) ? loadData : rdataReg;
  assign resp_err = state == RESP && capErr;
endmodule

// File: tb/tb_subword_mem_access.sv
// tb_subword_mem_access: directed plus random traffic against a byte-lane memory model.
// Honours SUBWORD_ALIGN_CHECK_EN the same way the design does.
module tb_subword_mem_access;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_addr;
  logic [31:0] ram [1024];
  logic [31:0] refMem [16];
  logic [31:0] lastLoad = '0;
  int total = 0, bad = 0;

  subword_mem_access #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One access: model predicts by byte lanes, bench measures latency/handshake/RAM effects.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    logic [31:0] val, expRd;
    logic mis, isWord;
    int idx, k0, lat, expLat, weCnt, lowCnt;
    idx = int'(a[5:2]);
    isWord = sz == 2'd0 || sz == 2'd3;
`ifdef SUBWORD_ALIGN_CHECK_EN
    mis = (sz == 2'd1 && a[0]) || (isWord && a[1:0] != 2'd0);
`else
    mis = 1'b0;
`endif
    for (int k = 0; k < 4; k++) b[k] = refMem[idx][8*k +: 8];
    k0 = sz == 2'd2 ? int'(a[1:0]) : sz == 2'd1 ? 2 * int'(a[1]) : 0;
    val = '0;
    for (int k = k0; k < 4; k++) val |= 32'(b[k]) << (8 * (k - k0));
    if (wr && !mis) begin
      for (int k = 0; k < (isWord ? 4 : sz == 2'd2 ? 1 : 2); k++) b[k0 + k] = wd[8*k +: 8];
      refMem[idx] = {b[3], b[2], b[1], b[0]};
    end
    expRd = (!wr && !mis) ? val : lastLoad;
    lastLoad = expRd;
    expLat = (mis || (wr && isWord)) ? 1 : 2;
    for (int w = 0; w < 8 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_wdata = wd;
    req_addr = {20'($urandom), 6'b000000, a};
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; weCnt = 0; lowCnt = 0;
    do begin
      @(negedge clk);
      lat++;
      weCnt += int'(mem_we);
      lowCnt += int'(!req_ready);
    end while (!resp_valid && lat < 6);
    chk("latency", lat, expLat);
    chk("we_cycles", weCnt, (wr && !mis) ? 1 : 0);
    chk("ready_low", lowCnt, expLat);
    chk("rdata", resp_rdata, expRd);
    chk("err", resp_err, mis);
    @(negedge clk);
    chk("pulse", resp_valid, 1'b0);
    chk("ram", ram[idx], refMem[idx]);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) refMem[i] = '0;
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) txn(1'b1, 2'd0, 6'(i * 4), $urandom);
    txn(1'b1, 2'd0, 6'h14, 32'h0);
    txn(1'b1, 2'd0, 6'h14, 32'hDEADBEEF);
    chk("tp_word", ram[5], 32'hDEADBEEF);
    txn(1'b1, 2'd0, 6'h08, 32'h11223344);
    txn(1'b1, 2'd2, 6'h0A, 32'hFFFFFFAB);
    chk("tp_byte_rmw", ram[2], 32'h11AB3344);
    txn(1'b1, 2'd0, 6'h0C, 32'hCAFEF00D);
    txn(1'b0, 2'd1, 6'h0E, 32'h0);
    chk("tp_half_load", resp_rdata, 32'h0000CAFE);
    txn(1'b0, 2'd2, 6'h0D, 32'h0);
    chk("tp_byte_load", resp_rdata, 32'h00CAFEF0);
    txn(1'b1, 2'd0, 6'h00, 32'hAAAAAAAA);
    txn(1'b1, 2'd1, 6'h00, 32'h00001234);
    txn(1'b0, 2'd0, 6'h00, 32'h0);
    chk("tp_b2b", resp_rdata, 32'hAAAA1234);
    txn(1'b1, 2'd1, 6'h03, 32'h00005678);
    txn(1'b0, 2'd3, 6'h02, 32'h0);
    // Reset while a byte store sits in its merge cycle.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h09; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_we_pre", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_we", mem_we, 1'b0);
    chk("mid_valid", resp_valid, 1'b0);
    chk("mid_ready", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    lastLoad = '0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    chk("mid_no_resp", seen, 0);
    chk("mid_ram", ram[2], refMem[2]);
    chk("mid_rdata", resp_rdata, 32'h0);
    chk("mid_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 200; i++) txn(1'($urandom), 2'($urandom), 6'($urandom), $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
